ulpi_link_ctrl: RTL and testbench

ULPI_LINK_CTRL -- requirements
Module: ulpi_link_ctrl

---
 rtl/ulpi_link_ctrl.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_ulpi_link_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ulpi_link_ctrl.sv
// rtl/ulpi_link_ctrl.sv - ULPI link-side controller: register request queue, TX sequencing, RX decode
//
// Parameters: QDEPTH (request queue entries, power of 2, 2..16),
//             MAX_RETRY (re-issues allowed after PHY abort before a request fails).
// Build macro: ULPI_EXT_REG_EN enables extended register access (addr >= 0x30).
//
// Ports:
//   CLK_60M, NRST_A_USB        ULPI clock (rising edge), async active-low reset
//   USB_DATA/DIR/NXT/STP       ULPI bus; USB_RESETN follows NRST_A_USB, USB_CS tied high
//   REQ_*                      register request push (valid/ready), rw=1 write
//   RSP_*                      one-cycle response pulse with tag, read data, fail flag
//   RXCMD, RXCMD_STRB          last RX CMD byte (held) and its strobe
//   RX_DATA/STRB/END/ERR       received data byte, strobe, end-of-burst, RX CMD error
//   READY, STATE               link operational flag, current FSM state code
module ulpi_link_ctrl #(
    parameter int QDEPTH    = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic       CLK_60M,
    input  logic       NRST_A_USB,
    inout  wire  [7:0] USB_DATA,
    input  logic       USB_DIR,
    input  logic       USB_NXT,
    output logic       USB_STP,
    output logic       USB_RESETN,
    output logic       USB_CS,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic       REQ_RW,
    input  logic [7:0] REQ_ADDR,
    input  logic [7:0] REQ_WDATA,
    input  logic [3:0] REQ_TAG,
    output logic       RSP_VALID,
    output logic [3:0] RSP_TAG,
    output logic [7:0] RSP_RDATA,
    output logic       RSP_FAIL,
    output logic [7:0] RXCMD,
    output logic       RXCMD_STRB,
    output logic [7:0] RX_DATA,
    output logic       RX_STRB,
    output logic       RX_END,
    output logic       RX_ERR,
    output logic       READY,
    output logic [3:0] STATE
);

    localparam int          AW          = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [AW:0] FULL        = (AW+1)'(QDEPTH);
    // Original attempt plus MAX_RETRY re-issues; the head fails once this many aborts occurred.
    localparam logic [7:0]  RETRY_LIMIT = 8'(MAX_RETRY + 1);

    typedef enum logic [3:0] {
        RESET    = 4'd0,
        WAIT_PHY = 4'd1,
        IDLE     = 4'd2,
        TXCMD    = 4'd3,
        EXTADDR  = 4'd4,
        WDATA    = 4'd5,
        STOP     = 4'd6,
        RTURN    = 4'd7,
        RDATA    = 4'd8,
        RX       = 4'd9,
        DONE     = 4'd10
    } state_t;

    state_t r_state, w_state_nxt;

    logic          r_q_rw    [QDEPTH];
    logic [7:0]    r_q_addr  [QDEPTH];
    logic [7:0]    r_q_wdata [QDEPTH];
    logic [3:0]    r_q_tag   [QDEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;

    logic [7:0] r_retry;
    logic       r_fail;
    logic [7:0] r_rdata;
    logic       r_dir_q;
    logic       r_got_data;
    logic [7:0] r_rxcmd, r_rx_data;
    logic       r_rxcmd_strb, r_rx_strb, r_rx_end, r_rx_err;

    logic       w_push, w_pop, w_abort, w_fail_now, w_drive, w_ext_bad;
    logic       w_h_rw;
    logic [7:0] w_h_addr, w_h_wdata, w_tx_data;
    logic [3:0] w_h_tag;
    logic [5:0] w_cmd_addr;

    assign w_h_rw    = r_q_rw[r_rd_ptr];
    assign w_h_addr  = r_q_addr[r_rd_ptr];
    assign w_h_wdata = r_q_wdata[r_rd_ptr];
    assign w_h_tag   = r_q_tag[r_rd_ptr];

    assign REQ_READY = (r_count != FULL);
    assign w_push    = REQ_VALID && REQ_READY;
    assign w_pop     = (r_state == DONE);

`ifdef ULPI_EXT_REG_EN
    logic w_ext;
    assign w_ext      = (w_h_addr >= 8'h30);
    assign w_ext_bad  = 1'b0;
    assign w_cmd_addr = w_ext ? 6'h2F : w_h_addr[5:0];
`else
    // Without extended access the upper register space is unreachable: fail without bus activity.
    assign w_ext_bad  = (w_h_addr >= 8'h30);
    assign w_cmd_addr = w_h_addr[5:0];
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_abort     = 1'b0;
        w_fail_now  = 1'b0;
        case (r_state)
            RESET:    w_state_nxt = WAIT_PHY;
            WAIT_PHY: if (!USB_DIR) w_state_nxt = IDLE;
            IDLE: begin
                if (USB_DIR) begin
                    w_state_nxt = RX;
                end else if (r_count != '0) begin
                    if (r_retry == RETRY_LIMIT || w_ext_bad) begin
                        w_fail_now  = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = TXCMD;
                    end
                end
            end
            TXCMD: begin
                if (USB_DIR) begin
                    w_abort     = 1'b1;
                    w_state_nxt = RX;
                end else if (USB_NXT) begin
`ifdef ULPI_EXT_REG_EN
                    if (w_ext) w_state_nxt = EXTADDR;
                    else       w_state_nxt = w_h_rw ? WDATA : RTURN;
`else
                    w_state_nxt = w_h_rw ? WDATA : RTURN;
`endif
                end
            end
`ifdef ULPI_EXT_REG_EN
            EXTADDR: begin
                if (USB_DIR) begin
                    w_abort     = 1'b1;
                    w_state_nxt = RX;
                end else if (USB_NXT) begin
                    w_state_nxt = w_h_rw ? WDATA : RTURN;
                end
            end
`endif
            WDATA: begin
                if (USB_DIR) begin
                    w_abort     = 1'b1;
                    w_state_nxt = RX;
                end else if (USB_NXT) begin
                    w_state_nxt = STOP;
                end
            end
            STOP: w_state_nxt = DONE;
            RTURN: begin
                // First DIR-high cycle is the turnaround; NXT high there means the PHY took the bus for RX.
                if (USB_DIR && !r_dir_q) begin
                    if (USB_NXT) begin
                        w_abort     = 1'b1;
                        w_state_nxt = RX;
                    end else begin
                        w_state_nxt = RDATA;
                    end
                end
            end
            RDATA: begin
                if (USB_DIR && !USB_NXT) begin
                    w_state_nxt = DONE;
                end else begin
                    w_abort     = 1'b1;
                    w_state_nxt = RX;
                end
            end
            RX:      if (!USB_DIR) w_state_nxt = IDLE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = RESET;
        endcase
    end

    always_comb begin
        w_tx_data = 8'h00;
        case (r_state)
            TXCMD:   w_tx_data = {1'b1, ~w_h_rw, w_cmd_addr};
`ifdef ULPI_EXT_REG_EN
            EXTADDR: w_tx_data = w_h_addr;
`endif
            WDATA:   w_tx_data = w_h_wdata;
            default: w_tx_data = 8'h00;
        endcase
    end

    // Drive only after DIR has been low for two cycles so a turnaround never overlaps the PHY.
    assign w_drive  = !USB_DIR && !r_dir_q && (r_state != RESET);
    assign USB_DATA = w_drive ? w_tx_data : 8'hzz;

    assign USB_STP    = (r_state == RESET) || (r_state == STOP);
    assign USB_RESETN = NRST_A_USB;
    assign USB_CS     = 1'b1;
    assign RSP_VALID  = (r_state == DONE);
    assign RSP_TAG    = (r_state == DONE) ? w_h_tag : 4'h0;
    assign RSP_RDATA  = (r_state == DONE) ? r_rdata : 8'h00;
    assign RSP_FAIL   = (r_state == DONE) && r_fail;
    assign RXCMD      = r_rxcmd;
    assign RXCMD_STRB = r_rxcmd_strb;
    assign RX_DATA    = r_rx_data;
    assign RX_STRB    = r_rx_strb;
    assign RX_END     = r_rx_end;
    assign RX_ERR     = r_rx_err;
    assign READY      = (r_state != RESET) && (r_state != WAIT_PHY);
    assign STATE      = r_state;

    always_ff @(posedge CLK_60M) begin
        if (w_push) begin
            r_q_rw[r_wr_ptr]    <= REQ_RW;
            r_q_addr[r_wr_ptr]  <= REQ_ADDR;
            r_q_wdata[r_wr_ptr] <= REQ_WDATA;
            r_q_tag[r_wr_ptr]   <= REQ_TAG;
        end
    end

    always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
        if (!NRST_A_USB) begin
            r_state      <= RESET;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_retry      <= 8'h00;
            r_fail       <= 1'b0;
            r_rdata      <= 8'h00;
            r_dir_q      <= 1'b0;
            r_got_data   <= 1'b0;
            r_rxcmd      <= 8'h00;
            r_rx_data    <= 8'h00;
            r_rxcmd_strb <= 1'b0;
            r_rx_strb    <= 1'b0;
            r_rx_end     <= 1'b0;
            r_rx_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dir_q <= USB_DIR;

            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_pop)        r_retry <= 8'h00;
            else if (w_abort) r_retry <= r_retry + 8'h01;

            if (r_state == IDLE) begin
                r_fail  <= w_fail_now;
                r_rdata <= 8'h00;
            end
            if (r_state == RDATA && USB_DIR && !USB_NXT) r_rdata <= USB_DATA;

            r_rxcmd_strb <= 1'b0;
            r_rx_strb    <= 1'b0;
            r_rx_end     <= 1'b0;
            r_rx_err     <= 1'b0;
            if (r_state == RX) begin
                if (!USB_DIR) begin
                    r_rx_end   <= r_got_data;
                    r_got_data <= 1'b0;
                end else if (r_dir_q) begin
                    if (USB_NXT) begin
                        r_rx_data  <= USB_DATA;
                        r_rx_strb  <= 1'b1;
                        r_got_data <= 1'b1;
                    end else begin
                        r_rxcmd      <= USB_DATA;
                        r_rxcmd_strb <= 1'b1;
                        r_rx_err     <= (USB_DATA[5:4] == 2'b11);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ulpi_link_ctrl.sv
// tb/tb_ulpi_link_ctrl.sv - directed self-checking bench for ulpi_link_ctrl
module tb_ulpi_link_ctrl;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       phy_dir = 1'b0, phy_nxt = 1'b0;
    logic [7:0] phy_dat = 8'h00;
    wire  [7:0] usb_data;
    logic       usb_stp, usb_resetn, usb_cs;
    logic       req_valid = 1'b0, req_rw = 1'b0;
    logic [7:0] req_addr = 8'h00, req_wdata = 8'h00;
    logic [3:0] req_tag = 4'h0;
    logic       req_ready;
    logic       rsp_valid, rsp_fail;
    logic [3:0] rsp_tag;
    logic [7:0] rsp_rdata;
    logic [7:0] rxcmd, rx_data;
    logic       rxcmd_strb, rx_strb, rx_end, rx_err;
    logic       ready;
    logic [3:0] state;

    int n_checks = 0;
    int n_errors = 0;

    int         rx_entries = 0, rx_strbs = 0, rx_ends = 0;
    logic [3:0] prev_state = 4'h0;
    logic [3:0] log_tag[$];
    logic       log_fail[$];
    logic [7:0] log_rdata[$];

    always #5 clk = ~clk;

    assign usb_data = phy_dir ? phy_dat : 8'hzz;

    ulpi_link_ctrl #(.QDEPTH(4), .MAX_RETRY(1)) dut (
        .CLK_60M    (clk),
        .NRST_A_USB (nrst),
        .USB_DATA   (usb_data),
        .USB_DIR    (phy_dir),
        .USB_NXT    (phy_nxt),
        .USB_STP    (usb_stp),
        .USB_RESETN (usb_resetn),
        .USB_CS     (usb_cs),
        .REQ_VALID  (req_valid),
        .REQ_READY  (req_ready),
        .REQ_RW     (req_rw),
        .REQ_ADDR   (req_addr),
        .REQ_WDATA  (req_wdata),
        .REQ_TAG    (req_tag),
        .RSP_VALID  (rsp_valid),
        .RSP_TAG    (rsp_tag),
        .RSP_RDATA  (rsp_rdata),
        .RSP_FAIL   (rsp_fail),
        .RXCMD      (rxcmd),
        .RXCMD_STRB (rxcmd_strb),
        .RX_DATA    (rx_data),
        .RX_STRB    (rx_strb),
        .RX_END     (rx_end),
        .RX_ERR     (rx_err),
        .READY      (ready),
        .STATE      (state)
    );

    always @(negedge clk) begin
        if (rsp_valid) begin
            log_tag.push_back(rsp_tag);
            log_fail.push_back(rsp_fail);
            log_rdata.push_back(rsp_rdata);
        end
        if (rx_strb) rx_strbs++;
        if (rx_end)  rx_ends++;
        if (state == 4'd9 && prev_state != 4'd9) rx_entries++;
        prev_state = state;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic phy(input logic d, input logic n, input logic [7:0] v);
        phy_dir = d;
        phy_nxt = n;
        phy_dat = v;
        #1;
    endtask

    task automatic push(input logic rw, input logic [7:0] a, input logic [7:0] wd, input logic [3:0] t);
        req_rw    = rw;
        req_addr  = a;
        req_wdata = wd;
        req_tag   = t;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        for (int k = 0; k < 30; k++) begin
            step();
            if (rsp_valid) break;
        end
        chk(tag, rsp_valid, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_tags [10];
        exp_tags = '{4'd3, 4'd5, 4'd9, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};

        // reset state
        #12;
        chk("rst_stp", usb_stp, 1);
        chk("rst_ready", ready, 0);
        chk("rst_state", state, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rxcmd", rxcmd, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resetn", usb_resetn, 0);
        chk("cs", usb_cs, 1);
        #9 nrst = 1'b1;
        step();
        chk("wait_phy_state", state, 1);
        chk("wait_phy_stp", usb_stp, 0);
        chk("wait_phy_ready", ready, 0);
        step();
        chk("idle_state", state, 2);
        chk("idle_ready", ready, 1);

        // write 0x04 <- 0x45 tag 3
        push(1'b1, 8'h04, 8'h45, 4'd3);
        step();
        phy(0, 1, 8'h00);
        chk("wr_txcmd_state", state, 3);
        chk("wr_txcmd_bus", usb_data, 8'h84);
        step();
        chk("wr_wdata_bus", usb_data, 8'h45);
        step();
        phy(0, 0, 8'h00);
        chk("wr_stop_stp", usb_stp, 1);
        chk("wr_stop_bus", usb_data, 8'h00);
        step();
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_rsp_tag", rsp_tag, 3);
        chk("wr_rsp_fail", rsp_fail, 0);
        chk("wr_rsp_rdata", rsp_rdata, 0);
        step();
        chk("wr_rsp_pulse", rsp_valid, 0);

        // read 0x0A tag 5, PHY returns 0x5A
        push(1'b0, 8'h0A, 8'h00, 4'd5);
        step();
        phy(0, 1, 8'h00);
        chk("rd_txcmd_bus", usb_data, 8'hCA);
        step();
        phy(0, 0, 8'h00);
        chk("rd_rturn_state", state, 7);
        step();
        phy(1, 0, 8'hEE);
        step();
        chk("rd_rdata_state", state, 8);
        phy(1, 0, 8'h5A);
        step();
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rsp_rdata", rsp_rdata, 8'h5A);
        chk("rd_rsp_fail", rsp_fail, 0);
        phy(0, 0, 8'h00);
        step();

        // abort twice during WDATA, MAX_RETRY = 1
        push(1'b1, 8'h10, 8'h99, 4'd9);
        for (int a = 0; a < 2; a++) begin
            step();
            phy(0, 1, 8'h00);
            chk("ab_txcmd_bus", usb_data, 8'h90);
            step();
            phy(1, 0, 8'h00);
            step();
            chk("ab_rx_state", state, 9);
            phy(0, 0, 8'h00);
            step();
        end
        step();
        chk("ab_rsp_valid", rsp_valid, 1);
        chk("ab_rsp_fail", rsp_fail, 1);
        chk("ab_rsp_tag", rsp_tag, 9);
        step();
        step();
        chk("ab_q_empty_idle", state, 2);
        chk("ab_rx_entries", rx_entries, 2);

        // RX burst
        phy(1, 0, 8'h00);
        step();
        phy(1, 0, 8'h3C);
        step();
        chk("rx_cmd_strb", rxcmd_strb, 1);
        chk("rx_err", rx_err, 1);
        chk("rx_cmd", rxcmd, 8'h3C);
        phy(1, 1, 8'h11);
        step();
        chk("rx_strb1", rx_strb, 1);
        chk("rx_data1", rx_data, 8'h11);
        chk("rx_cmd_strb_off", rxcmd_strb, 0);
        phy(1, 1, 8'h22);
        step();
        chk("rx_data2", rx_data, 8'h22);
        phy(0, 0, 8'h00);
        step();
        chk("rx_end", rx_end, 1);
        step();
        chk("rx_end_pulse", rx_end, 0);
        chk("rx_strb_count", rx_strbs, 2);
        chk("rx_end_count", rx_ends, 1);

        // queue fill while PHY holds the bus
        phy(1, 0, 8'h00);
        step();
        for (int i = 1; i <= 4; i++) begin
            chk("q_ready_before_full", req_ready, 1);
            push(1'b1, 8'h01, 8'(i), 4'(i));
        end
        chk("q_full_ready", req_ready, 0);
        push(1'b1, 8'h01, 8'hFF, 4'hF);
        chk("q_full_hold", req_ready, 0);
        phy(0, 1, 8'h00);
        step();
        wait_rsp("q_rsp1");
        wait_rsp("q_rsp2");
        push(1'b1, 8'h02, 8'h55, 4'd5);
        chk("q_pushpop_ready", req_ready, 1);
        push(1'b1, 8'h03, 8'h66, 4'd6);
        chk("q_refull_ready", req_ready, 0);
        for (int i = 0; i < 4; i++) wait_rsp("q_rsp_rest");
        phy(0, 0, 8'h00);
        step();

        // read 0x35
        push(1'b0, 8'h35, 8'h00, 4'd7);
        step();
`ifdef ULPI_EXT_REG_EN
        phy(0, 1, 8'h00);
        chk("ext_txcmd_bus", usb_data, 8'hEF);
        step();
        chk("ext_extaddr_state", state, 4);
        chk("ext_extaddr_bus", usb_data, 8'h35);
        step();
        phy(1, 0, 8'h00);
        step();
        phy(1, 0, 8'hA7);
        step();
        chk("ext_rsp_valid", rsp_valid, 1);
        chk("ext_rsp_rdata", rsp_rdata, 8'hA7);
        chk("ext_rsp_fail", rsp_fail, 0);
        phy(0, 0, 8'h00);
`else
        chk("noext_done_state", state, 10);
        chk("noext_rsp_valid", rsp_valid, 1);
        chk("noext_rsp_fail", rsp_fail, 1);
        chk("noext_rsp_tag", rsp_tag, 7);
        chk("noext_bus_idle", usb_data, 8'h00);
`endif
        step();

        // response order and contents
        chk("log_size", log_tag.size(), 10);
        for (int i = 0; i < 10; i++) chk($sformatf("log_tag%0d", i), log_tag[i], exp_tags[i]);
        chk("log_rd_rdata", log_rdata[1], 8'h5A);
        chk("log_ab_fail", log_fail[2], 1);
        chk("log_q_fail", log_fail[3], 0);

        // reset mid-transaction discards the queue
        push(1'b1, 8'h02, 8'h11, 4'd8);
        step();
        chk("mid_txcmd_state", state, 3);
        nrst = 1'b0;
        #1;
        chk("mid_rst_state", state, 0);
        chk("mid_rst_stp", usb_stp, 1);
        chk("mid_rst_req_ready", req_ready, 1);
        chk("mid_rst_ready", ready, 0);
        step();
        nrst = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("mid_idle_state", state, 2);
        chk("mid_no_rsp", log_tag.size(), 10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
